// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch unit: one fetch in flight over an AR/R read channel, result handed to decode.
// Optional IFU_MISALIGN_CHECK_EN: misaligned PCs fault locally instead of being sent to memory.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] ERR_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        pc_update,
    output logic        imem_arvalid,
    output logic [31:0] imem_araddr,
    input  logic        imem_arready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  imem_rresp,
    output logic        imem_rready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pc_val,
    output logic [31:0] instr,
    output logic        fetch_err,
    output logic        busy
);

    localparam int unsigned XLEN = 32;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        RESP   = 3'd2,
        VALID  = 3'd3,
        WAITPC = 3'd4
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [XLEN-1:0]   pc_n;
    logic [XLEN-1:0]   instr_n;
    logic              err_n;
    logic              arvalid_n;
    logic              rready_n;
    logic              out_valid_n;
    logic              busy_n;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_n     = state;
        pc_n        = pc_val;
        instr_n     = instr;
        err_n       = fetch_err;
        arvalid_n   = 1'b0;
        rready_n    = 1'b0;
        out_valid_n = 1'b0;
        busy_n      = 1'b1;

        unique case (state)
            IDLE: begin
                state_n = REQ;
            end
            REQ: begin
`ifdef IFU_MISALIGN_CHECK_EN
                if (pc_val[1:0] != 2'b00) begin
                    state_n = VALID;
                    instr_n = ERR_INSTR;
                    err_n   = 1'b1;
                end else
`endif
                if (imem_arvalid && imem_arready) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (imem_rvalid) begin
                    state_n = VALID;
                    err_n   = (imem_rresp != RESP_OKAY);
                    instr_n = (imem_rresp == RESP_OKAY) ? imem_rdata : ERR_INSTR;
                end
            end
            VALID: begin
                // A commit in the same cycle as the decode handshake skips WAITPC
                if (out_ready) begin
                    if (pc_update) begin
                        pc_n    = next_pc;
                        state_n = REQ;
                    end else begin
                        state_n = WAITPC;
                    end
                end
            end
            WAITPC: begin
                if (pc_update) begin
                    pc_n    = next_pc;
                    state_n = REQ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Handshake outputs follow the state being entered so they are registered
        arvalid_n = (state_n == REQ);
`ifdef IFU_MISALIGN_CHECK_EN
        if (pc_n[1:0] != 2'b00) begin
            arvalid_n = 1'b0;
        end
`endif
        rready_n    = (state_n == RESP);
        out_valid_n = (state_n == VALID);
        busy_n      = (state_n != IDLE);
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_val       <= RESET_PC;
            instr        <= '0;
            fetch_err    <= 1'b0;
            imem_arvalid <= 1'b0;
            imem_rready  <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            pc_val       <= pc_n;
            instr        <= instr_n;
            fetch_err    <= err_n;
            imem_arvalid <= arvalid_n;
            imem_rready  <= rready_n;
            out_valid    <= out_valid_n;
            busy         <= busy_n;
        end
    end

    assign imem_araddr = pc_val;

`ifndef SYNTHESIS
    // Protocol checks on the surrounding stages
    always @(posedge clk) begin
        if (!rst) begin
            assert (!pc_update || state == VALID || state == WAITPC)
                else $error("ifu_fetch: pc_update while no instruction is presented or awaiting commit");
            assert (!imem_rvalid || state == RESP)
                else $error("ifu_fetch: read data beat outside a pending fetch");
        end
    end
`endif

endmodule
